// File: rtl/cp2_chan_bridge_if.sv
// CPU-side cp2 strobe bus plus the per-channel coprocessor array signals.
// The master modport is the environment (CPU and coprocessors); the slave is the bridge.
interface cp2_chan_bridge_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CODE_W = 4
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CH_W-1:0]          cpu_ch;
    logic                     cpu_ts;
    logic                     cpu_fs;
    logic                     cpu_as;
    logic [DATA_W-1:0]        cpu_tdata;
    logic                     cpu_busy;
    logic                     cpu_fds;
    logic [DATA_W-1:0]        cpu_fdata;
    logic                     cpu_excs;
    logic [CH_W-1:0]          cpu_exc_ch;
    logic [CODE_W-1:0]        cpu_exccode;
    logic                     cpu_exc_ack;

    logic [NUM_CH-1:0]        cp_ts;
    logic [NUM_CH-1:0]        cp_fs;
    logic [NUM_CH-1:0]        cp_as;
    logic [NUM_CH*DATA_W-1:0] cp_tdata;
    logic [NUM_CH-1:0]        cp_tbusy;
    logic [NUM_CH-1:0]        cp_fbusy;
    logic [NUM_CH-1:0]        cp_abusy;
    logic [NUM_CH-1:0]        cp_fds;
    logic [NUM_CH*DATA_W-1:0] cp_fdata;
    logic [NUM_CH-1:0]        cp_excs;
    logic [NUM_CH*CODE_W-1:0] cp_exccode;

    modport master (
        output cpu_ch, cpu_ts, cpu_fs, cpu_as, cpu_tdata, cpu_exc_ack,
        input  cpu_busy, cpu_fds, cpu_fdata, cpu_excs, cpu_exc_ch, cpu_exccode,
        input  cp_ts, cp_fs, cp_as, cp_tdata,
        output cp_tbusy, cp_fbusy, cp_abusy, cp_fds, cp_fdata, cp_excs, cp_exccode
    );

    modport slave (
        input  cpu_ch, cpu_ts, cpu_fs, cpu_as, cpu_tdata, cpu_exc_ack,
        output cpu_busy, cpu_fds, cpu_fdata, cpu_excs, cpu_exc_ch, cpu_exccode,
        output cp_ts, cp_fs, cp_as, cp_tdata,
        input  cp_tbusy, cp_fbusy, cp_abusy, cp_fds, cp_fdata, cp_excs, cp_exccode
    );
endinterface

// File: rtl/cp2_chan_bridge.sv
// Bridges the single CPU cp2 strobe bus onto NUM_CH coprocessor channels: per-channel
// to-FIFOs, one outstanding from-transfer with timeout, action sequencing, exception report.
module cp2_chan_bridge #(
    parameter int unsigned        DATA_W    = 32,
    parameter int unsigned        NUM_CH    = 4,
    parameter int unsigned        DEPTH     = 4,
    parameter int unsigned        CODE_W    = 4,
    parameter int unsigned        TO_CYCLES = 255,
    parameter logic [CODE_W-1:0]  TO_CODE   = CODE_W'(4'hF)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    cp2_chan_bridge_if.slave  bus
);
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TO_W  = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} fsm_e;

    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] fifo_full;
    logic              fsm_busy;
    logic              cpu_busy;
    logic              ts_acc;
    logic              fs_acc;
    logic              as_acc;

    fsm_e              state_q, state_d;
    logic [CH_W-1:0]   fch_q, fch_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [DATA_W-1:0] fdata_q, fdata_d;
    logic              timeout;

    logic              act_pend_q, act_pend_d;
    logic [CH_W-1:0]   act_ch_q, act_ch_d;

    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [CODE_W-1:0] code_q [NUM_CH];
    logic [CODE_W-1:0] code_d [NUM_CH];
    logic [CH_W-1:0]   rpt_ch;

    // Ordering: fs/as to a channel wait until its to-FIFO has drained.
    assign fsm_busy = (state_q == StReq) || (state_q == StWait);
    assign cpu_busy = (bus.cpu_ts & fifo_full[bus.cpu_ch])
                    | fsm_busy
                    | act_pend_q
                    | ((bus.cpu_fs | bus.cpu_as) & ~fifo_empty[bus.cpu_ch]);

    assign ts_acc = bus.cpu_ts & ~cpu_busy;
    assign fs_acc = bus.cpu_fs & ~cpu_busy;
    assign as_acc = bus.cpu_as & ~cpu_busy;

    assign bus.cpu_busy = cpu_busy;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
        logic [DATA_W-1:0] mem_q [DEPTH];
        logic [PTR_W-1:0]  wptr_q;
        logic [PTR_W-1:0]  rptr_q;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic              push;
        logic              pop;

        assign fifo_empty[g] = (cnt_q == '0);
        assign fifo_full[g]  = (cnt_q == CNT_W'(DEPTH));
        assign push = ts_acc && (bus.cpu_ch == CH_W'(g)) && !fifo_full[g];
        assign pop  = !fifo_empty[g] && !bus.cp_tbusy[g];

        always_comb begin
            cnt_d = cnt_q;
            if (push && !pop) begin
                cnt_d = cnt_q + 1'b1;
            end else if (!push && pop) begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (push) wptr_q <= wptr_q + 1'b1;
                if (pop)  rptr_q <= rptr_q + 1'b1;
                cnt_q <= cnt_d;
            end
        end

        always_ff @(posedge clk_i) begin
            if (push) mem_q[wptr_q] <= bus.cpu_tdata;
        end

        // Head is masked while empty so stale storage never reaches the channel.
        assign bus.cp_ts[g] = !fifo_empty[g];
        assign bus.cp_tdata[g*DATA_W +: DATA_W] = fifo_empty[g] ? '0 : mem_q[rptr_q];
    end

    always_comb begin
        state_d  = state_q;
        fch_d    = fch_q;
        to_cnt_d = to_cnt_q;
        fdata_d  = fdata_q;
        timeout  = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (fs_acc) begin
                    state_d = StReq;
                    fch_d   = bus.cpu_ch;
                end else begin
                    state_d = StIdle;
                end
            end
            StReq: begin
                if (!bus.cp_fbusy[fch_q]) begin
                    state_d  = StWait;
                    to_cnt_d = '0;
                end
            end
            StWait: begin
                if (bus.cp_fds[fch_q]) begin
                    fdata_d = bus.cp_fdata[fch_q*DATA_W +: DATA_W];
                    state_d = StDone;
                end else if ((TO_CYCLES != 0) && (to_cnt_q == TO_W'(TO_CYCLES - 1))) begin
                    timeout = 1'b1;
                    fdata_d = '0;
                    state_d = StDone;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            fch_q    <= '0;
            to_cnt_q <= '0;
            fdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            fch_q    <= fch_d;
            to_cnt_q <= to_cnt_d;
            fdata_q  <= fdata_d;
        end
    end

    assign bus.cp_fs     = (state_q == StReq) ? (NUM_CH'(1) << fch_q) : '0;
    assign bus.cpu_fds   = (state_q == StDone);
    assign bus.cpu_fdata = fdata_q;

    always_comb begin
        act_pend_d = act_pend_q;
        act_ch_d   = act_ch_q;
        if (act_pend_q && !bus.cp_abusy[act_ch_q]) begin
            act_pend_d = 1'b0;
        end
        if (as_acc) begin
            act_pend_d = 1'b1;
            act_ch_d   = bus.cpu_ch;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            act_pend_q <= 1'b0;
            act_ch_q   <= '0;
        end else begin
            act_pend_q <= act_pend_d;
            act_ch_q   <= act_ch_d;
        end
    end

    assign bus.cp_as = act_pend_q ? (NUM_CH'(1) << act_ch_q) : '0;

    always_comb begin
        rpt_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend_q[i]) rpt_ch = CH_W'(i);
        end
    end

    // Ack clears first so a same-cycle strobe on the reported channel re-arms it;
    // the internal timeout takes precedence over an external strobe on its channel.
    always_comb begin
        pend_d = pend_q;
        code_d = code_q;
        if (bus.cpu_exc_ack && (|pend_q)) begin
            pend_d[rpt_ch] = 1'b0;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!pend_d[i]) begin
                if (timeout && (fch_q == CH_W'(i))) begin
                    pend_d[i] = 1'b1;
                    code_d[i] = TO_CODE;
                end else if (bus.cp_excs[i]) begin
                    pend_d[i] = 1'b1;
                    code_d[i] = bus.cp_exccode[i*CODE_W +: CODE_W];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
            code_q <= '{default: '0};
        end else begin
            pend_q <= pend_d;
            code_q <= code_d;
        end
    end

    assign bus.cpu_excs    = |pend_q;
    assign bus.cpu_exc_ch  = rpt_ch;
    assign bus.cpu_exccode = (|pend_q) ? code_q[rpt_ch] : '0;

endmodule
